branch_arm_counter: RTL and testbench
=====================================

# branch_arm_counter

Synthesizable branch-coverage collector that sits directly downstream of the two-condition `if (x) … else if (y) …` decision block. It watches the same `x`/`y` conditions, re-evaluates the decision whenever either condition changes, and counts hits per arm: if, else-if, and implicit else. Saturating per-arm counters are read out through a snapshot dump sequence with a valid/ready handshake, giving the UCDB flow a hardware-side branch hit count to cross-check against simulator coverage.

## Interface
- `CNT_W`, default 16: width of each per-arm hit counter (≥2).
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `x` in 1: first branch condition (if arm); synchronous to `clk`.
- `y` in 1: second branch condition (else-if arm).
- `clr` in 1: single-cycle pulse; zeroes all live counters.
- `dump_req` in 1: request a snapshot dump; sampled only in IDLE.
- `dump_ready` in 1: downstream accepts the current dump beat.
- `dump_valid` out 1: dump beat valid.
- `dump_arm` out 2: arm index of the current beat (0=IF, 1=ELSIF, 2=ELSE).
- `dump_data` out CNT_W: snapshot count for `dump_arm`.
- `dump_last` out 1: high on the ELSE beat.
- `busy` out 1: high while the FSM is in DUMP.
- `hit_valid` out 1: one-cycle pulse per evaluation.
- `hit_arm` out 2: arm taken by that evaluation.

## Operation
- The block registers `{x,y}` into `prev_xy` every cycle. An evaluation occurs in any cycle where `{x,y} != prev_xy`. This matches the `@(x or y)` sensitivity: an evaluation needs a change, so an unchanged level causes no evaluation.
- Arm selection is priority-ordered:
  - `x`=1 → IF.
  - `x`=0 and `y`=1 → ELSIF.
  - Otherwise → ELSE.
- Each evaluation increments that arm's counter by 1. Counters saturate at 2^CNT_W−1 and never wrap.
- FSM states are IDLE and DUMP.
  - IDLE → DUMP when `dump_req`=1. On that edge all three live counters are copied into snapshot registers and the beat index is set to 0.
  - In DUMP, beats are presented in order IF, ELSIF, ELSE. A beat completes on `dump_valid && dump_ready`.
  - Completion of the ELSE beat (`dump_last`) returns the FSM to IDLE.
- `dump_req` during DUMP is ignored and is not queued.
- Counting continues during DUMP. Snapshot values are frozen for the whole dump.
- `clr` coinciding with an evaluation leaves the hit arm's counter at 1 and the others at 0. `clr` never alters the snapshot.
- `rst` mid-dump aborts the dump immediately. The FSM returns to IDLE and all counters and snapshots are zeroed.

## Timing
- Reset values:
  - `dump_valid`, `busy`, `hit_valid`, `dump_last` = 0.
  - `dump_arm` = 0, `dump_data` = 0, `hit_arm` = 0.
  - All counters, snapshots and `prev_xy` = 0.
- Evaluation latency: a change in `{x,y}` at edge N produces `hit_valid`/`hit_arm` registered at edge N+1. The counter shows the new value from edge N+1.
- A condition change on every cycle yields an evaluation on every cycle. There is no drop and no coalescing.
- Dump:
  - `dump_req` sampled at edge N gives `busy` and `dump_valid` high from edge N+1, with the first beat (IF) presented then.
  - With `dump_ready` held high, the dump takes exactly 3 cycles and `busy` falls at edge N+4.
- `dump_arm`, `dump_data` and `dump_last` hold stable while `dump_valid && !dump_ready`.
- `dump_valid` never drops without a completed handshake, except on `rst`.

## Configuration
- Macro `BRANCH_ARM_COUNTER_INIT_EVAL_EN`.
- Defined: the first cycle after `rst` deasserts counts as an evaluation of the current `{x,y}`, regardless of `prev_xy`, and pulses `hit_valid`. This models a time-zero evaluation.
- Undefined: only changes relative to `prev_xy` (reset value 00) evaluate. Holding `x=y=0` out of reset counts nothing.

## Structure
- Package `branch_arm_pkg` holds:
  - `arm_e` enum: ARM_IF=0, ARM_ELSIF=1, ARM_ELSE=2.
  - `NUM_ARMS`=3.
  - `state_e`: IDLE, DUMP.
- Sub-module `branch_arm_sat_cnt`: one CNT_W saturating counter with `clr` and `inc` inputs, using clear-then-increment priority. It is instantiated once per arm.
- The top level contains change detection, arm decode, the FSM and the snapshot registers.

## Test plan
- Reset, then `x`=1 at cycle 2, `x`=0 at cycle 3, `y`=1 at cycle 4 → hits IF, ELSE, ELSIF. A dump returns 1, 1, 1 with `dump_last` on beat 3.
- `x`=1 held for 10 cycles → exactly one IF hit. Counts are IF=1, ELSIF=0, ELSE=0.
- CNT_W=2, toggle `x` eight times → IF saturates at 3 and ELSE saturates at 3, with no wrap to 0.
- Dump with `dump_ready` low for 4 cycles on beat 0, while new IF hits arrive → beat 0 data stays at the snapshot value and is stable. A second dump shows the updated live counts.
- `clr` in the same cycle as an ELSIF hit, with ELSIF=5 beforehand → ELSIF=1 and the other arms are 0.
- `rst` asserted during beat 1 of a dump → next cycle `dump_valid`=0 and `busy`=0. Macro defined with `x=y=0` → ELSE=1 after release. Macro undefined → ELSE=0.

Source files
------------

// File: rtl/branch_arm_pkg.sv
// Shared types for the branch-arm coverage counter: arm indices, FSM states
// and the priority decode of the two-condition if / else-if decision.
package branch_arm_pkg;

  localparam int NUM_ARMS = 3;

  typedef enum logic [1:0] {
    ARM_IF    = 2'd0,
    ARM_ELSIF = 2'd1,
    ARM_ELSE  = 2'd2
  } arm_e;

  typedef enum logic {
    IDLE = 1'b0,
    DUMP = 1'b1
  } state_e;

  // x wins over y, matching the source decision's if / else-if order.
  function automatic arm_e decode_arm(input logic x, input logic y);
    if (x)      return ARM_IF;
    else if (y) return ARM_ELSIF;
    else        return ARM_ELSE;
  endfunction

endpackage

// File: rtl/branch_arm_sat_cnt.sv
// One saturating hit counter. A clear and an increment in the same cycle
// leave the counter at 1: the clear applies first, then the hit lands.
module branch_arm_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: cnt_d is given a default before any branch so no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = inc_i ? CNT_W'(1) : '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_arm_counter.sv
// Branch-coverage collector for an if / else-if / else decision on {x,y}.
// Define BRANCH_ARM_COUNTER_INIT_EVAL_EN to count a time-zero evaluation after reset.
module branch_arm_counter
  import branch_arm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             y,
  input  logic             clr,
  input  logic             dump_req,
  input  logic             dump_ready,
  output logic             dump_valid,
  output logic [1:0]       dump_arm,
  output logic [CNT_W-1:0] dump_data,
  output logic             dump_last,
  output logic             busy,
  output logic             hit_valid,
  output logic [1:0]       hit_arm
);

  logic [1:0]       prev_xy_q;
  logic             eval;
  arm_e             arm;
  logic [CNT_W-1:0] cnt [NUM_ARMS];

  state_e           state_q, state_d;
  arm_e             beat_q, beat_d;
  logic [CNT_W-1:0] snap_q [NUM_ARMS];
  logic [CNT_W-1:0] snap_d [NUM_ARMS];

  logic             hit_valid_q;
  arm_e             hit_arm_q;

`ifdef BRANCH_ARM_COUNTER_INIT_EVAL_EN
  logic first_q;

  always_ff @(posedge clk) begin
    if (rst) first_q <= 1'b1;
    else     first_q <= 1'b0;
  end

  assign eval = ({x, y} != prev_xy_q) || first_q;
`else
  assign eval = ({x, y} != prev_xy_q);
`endif

  assign arm = decode_arm(x, y);

  for (genvar i = 0; i < NUM_ARMS; i++) begin : g_arm
    branch_arm_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (clr),
      .inc_i (eval && (arm == arm_e'(i))),
      .cnt_o (cnt[i])
    );
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    snap_d  = snap_q;
    unique case (state_q)
      IDLE: begin
        if (dump_req) begin
          state_d = DUMP;
          beat_d  = ARM_IF;
          snap_d  = cnt;
        end
      end
      DUMP: begin
        if (dump_ready) begin
          case (beat_q)
            ARM_IF:    beat_d = ARM_ELSIF;
            ARM_ELSIF: beat_d = ARM_ELSE;
            default:   state_d = IDLE;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the snapshot is a handful of flops that must read zero after a
  // reset, so unlike a RAM-style array it is reset explicitly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      beat_q      <= ARM_IF;
      prev_xy_q   <= 2'b00;
      hit_valid_q <= 1'b0;
      hit_arm_q   <= ARM_IF;
      for (int i = 0; i < NUM_ARMS; i++) snap_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      snap_q      <= snap_d;
      prev_xy_q   <= {x, y};
      hit_valid_q <= eval;
      if (eval) hit_arm_q <= arm;
    end
  end

  // Beat fields are forced to zero outside a dump so idle outputs stay clean.
  assign dump_valid = (state_q == DUMP);
  assign busy       = (state_q == DUMP);
  assign dump_arm   = dump_valid ? beat_q : ARM_IF;
  assign dump_data  = dump_valid ? snap_q[beat_q] : '0;
  assign dump_last  = dump_valid && (beat_q == ARM_ELSE);
  assign hit_valid  = hit_valid_q;
  assign hit_arm    = hit_arm_q;

endmodule

// File: tb/tb_branch_arm_counter.sv
// Self-checking bench for branch_arm_counter: directed scenarios then random
// traffic, all outputs compared each cycle against a queue-based model.
module tb_branch_arm_counter;

  localparam int CNT_W = 4;
  localparam int MAX   = (1 << CNT_W) - 1;
`ifdef BRANCH_ARM_COUNTER_INIT_EVAL_EN
  localparam bit INIT_EVAL = 1'b1;
`else
  localparam bit INIT_EVAL = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst, x, y, clr, dump_req, dump_ready;
  logic             dump_valid, dump_last, busy, hit_valid;
  logic [1:0]       dump_arm, hit_arm;
  logic [CNT_W-1:0] dump_data;

  int checks   = 0;
  int failures = 0;

  // Reference model: per-arm hit totals and a queue of beats still owed.
  int       m_cnt [3];
  int       m_dq [$];
  bit [1:0] m_prev;
  bit       m_first;
  bit       m_hv;
  int       m_ha;
  int       got [3];

  branch_arm_counter #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .x          (x),
    .y          (y),
    .clr        (clr),
    .dump_req   (dump_req),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_arm   (dump_arm),
    .dump_data  (dump_data),
    .dump_last  (dump_last),
    .busy       (busy),
    .hit_valid  (hit_valid),
    .hit_arm    (hit_arm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit ev;
    int a;
    if (rst) begin
      m_cnt   = '{0, 0, 0};
      m_dq.delete();
      m_prev  = 2'b00;
      m_hv    = 1'b0;
      m_ha    = 0;
      m_first = INIT_EVAL;
    end else begin
      ev      = ({x, y} != m_prev) || m_first;
      m_first = 1'b0;
      m_prev  = {x, y};
      a       = x ? 0 : (y ? 1 : 2);
      if (m_dq.size() == 0) begin
        if (dump_req) for (int i = 0; i < 3; i++) m_dq.push_back(m_cnt[i]);
      end else if (dump_ready) begin
        m_dq.delete(0);
      end
      if (clr) m_cnt = '{0, 0, 0};
      if (ev) begin
        m_cnt[a] = (m_cnt[a] >= MAX) ? MAX : m_cnt[a] + 1;
        m_ha     = a;
      end
      m_hv = ev;
    end
  endtask

  task automatic compare_all();
    int n;
    n = m_dq.size();
    check("dump_valid", dump_valid, n != 0);
    check("busy", busy, n != 0);
    check("dump_arm", dump_arm, (n != 0) ? 3 - n : 0);
    check("dump_data", dump_data, (n != 0) ? m_dq[0] : 0);
    check("dump_last", dump_last, n == 1);
    check("hit_valid", hit_valid, m_hv);
    check("hit_arm", hit_arm, m_ha);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic set_xy(input logic xv, input logic yv);
    x = xv;
    y = yv;
    tick();
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Full dump with ready held high; captures each accepted beat into got[].
  task automatic run_dump();
    got        = '{-1, -1, -1};
    dump_req   = 1'b1;
    dump_ready = 1'b1;
    tick();
    dump_req = 1'b0;
    for (int n = 0; n < 10 && dump_valid; n++) begin
      got[dump_arm] = int'(dump_data);
      tick();
    end
    check("dump_ends", dump_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; x = 1'b0; y = 1'b0; clr = 1'b0; dump_req = 1'b0; dump_ready = 1'b0;
    m_cnt = '{0, 0, 0};
    m_prev = 2'b00; m_first = 1'b0; m_hv = 1'b0; m_ha = 0;
    tick();
    tick();
    check("reset_valid", dump_valid, 1'b0);
    check("reset_data", dump_data, 0);
    rst = 1'b0;
    tick();
    pulse_clr();

    // IF, ELSE, ELSIF in consecutive cycles
    set_xy(1'b1, 1'b0);
    check("first_hit_if", hit_arm, 0);
    set_xy(1'b0, 1'b0);
    set_xy(1'b0, 1'b1);
    run_dump();
    check("t1_if", got[0], 1);
    check("t1_elsif", got[1], 1);
    check("t1_else", got[2], 1);

    // Held level gives a single hit
    pulse_clr();
    x = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    run_dump();
    check("t2_if", got[0], 1);
    check("t2_elsif", got[1], 0);
    check("t2_else", got[2], 0);

    // Saturation: IF and ELSE pinned at MAX
    clr = 1'b1;
    set_xy(1'b1, 1'b0);
    clr = 1'b0;
    for (int i = 0; i < 40; i++) set_xy(i[0], 1'b0);
    run_dump();
    check("t3_if_sat", got[0], MAX);
    check("t3_elsif", got[1], 0);
    check("t3_else_sat", got[2], MAX);

    // Stalled beat 0 stays frozen while live counts move
    set_xy(1'b0, 1'b0);
    pulse_clr();
    set_xy(1'b1, 1'b0);
    set_xy(1'b0, 1'b0);
    set_xy(1'b1, 1'b0);
    dump_req   = 1'b1;
    dump_ready = 1'b0;
    tick();
    dump_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_xy(i[0], 1'b0);
      check("stall_data", dump_data, 2);
      check("stall_arm", dump_arm, 0);
    end
    dump_ready = 1'b1;
    for (int n = 0; n < 5 && dump_valid; n++) tick();
    run_dump();
    check("t4_if", got[0], 4);
    check("t4_else", got[2], 3);

    // clr together with an ELSIF hit
    pulse_clr();
    for (int i = 0; i < 9; i++) set_xy(1'b0, ~i[0]);
    set_xy(1'b0, 1'b0);
    clr = 1'b1;
    set_xy(1'b0, 1'b1);
    clr = 1'b0;
    run_dump();
    check("t5_if", got[0], 0);
    check("t5_elsif", got[1], 1);
    check("t5_else", got[2], 0);

    // Reset mid-dump, then the time-zero evaluation behaviour
    dump_req   = 1'b1;
    dump_ready = 1'b1;
    tick();
    dump_req = 1'b0;
    tick();
    check("beat1_arm", dump_arm, 1);
    rst = 1'b1;
    x   = 1'b0;
    y   = 1'b0;
    tick();
    check("rst_abort_valid", dump_valid, 1'b0);
    check("rst_abort_busy", busy, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    check("init_hit", hit_valid, INIT_EVAL);
    tick();
    run_dump();
    check("init_else", got[2], INIT_EVAL ? 1 : 0);

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      x          = 1'($urandom_range(0, 1));
      y          = 1'($urandom_range(0, 1));
      clr        = ($urandom_range(0, 39) == 0);
      dump_req   = ($urandom_range(0, 9) == 0);
      dump_ready = ($urandom_range(0, 3) != 0);
      rst        = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
